m68k_bus_master: RTL and testbench

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

---
 rtl/m68k_bus_master.sv | 128 ++++++++++++
 tb/tb_m68k_bus_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: 68000-style asynchronous bus master for byte/word/long transfers.
// Define M68K_BUS_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC clocks with resp_err=3.
module m68k_bus_master #(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              C100,
  input  logic              RESET_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_fc,
  input  logic [1:0]        req_size,
  input  logic              req_read,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-2:0] A,
  output logic [2:0]        FC,
  output logic              A_oe,
  output logic              AS_n,
  output logic              RW_n,
  output logic              UDS_n,
  output logic              LDS_n,
  output logic [15:0]       D_out,
  output logic              D_oe,
  input  logic [15:0]       D_in,
  input  logic              DTACK_n,
  input  logic              BERR_n
);
  typedef enum logic [2:0] {IDLE, ADR, ASRT, DS, WAIT, LATCH, NEG, RESP} state_t;
  state_t r_state, w_next;
  logic dtack_q, berr_q;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0] r_fc;
  logic r_read, r_byte, r_long, r_second;
  logic [15:0] r_dout, r_wlo;
  logic [31:0] r_rdata;
  logic [1:0] r_err;
  logic w_accept, w_aerr, w_tout, w_as, w_ds;
  assign w_accept = req_valid && r_state == IDLE;
  assign w_aerr   = req_size != 2'd0 && req_addr[0];
`ifdef M68K_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  always_ff @(posedge C100 or negedge RESET_n)
    if (!RESET_n) r_tcnt <= '0;
    else          r_tcnt <= (r_state == WAIT) ? r_tcnt + TW'(1) : '0;
  assign w_tout = r_state == WAIT && r_tcnt == TW'(TIMEOUT_CYC - 1);
`else
  assign w_tout = TIMEOUT_CYC < 0;
`endif
  always_ff @(posedge C100 or negedge RESET_n)
    if (!RESET_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_aerr ? RESP : ADR) : IDLE;
      ADR:     w_next = ASRT;
      ASRT:    w_next = DS;
      DS:      w_next = WAIT;
      WAIT:    w_next = !berr_q ? NEG : !dtack_q ? LATCH : w_tout ? NEG : WAIT;
      LATCH:   w_next = NEG;
      NEG:     w_next = (r_long && !r_second && r_err == 2'd0) ? ADR : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge C100 or negedge RESET_n)
    if (!RESET_n) begin
      dtack_q  <= 1'b1;
      berr_q   <= 1'b1;
      r_addr   <= '0;
      r_fc     <= '0;
      r_read   <= 1'b0;
      r_byte   <= 1'b0;
      r_long   <= 1'b0;
      r_second <= 1'b0;
      r_dout   <= '0;
      r_wlo    <= '0;
      r_rdata  <= '0;
      r_err    <= '0;
    end else begin
      dtack_q <= DTACK_n;
      berr_q  <= BERR_n;
      if (w_accept) begin
        r_addr   <= req_addr;
        r_fc     <= req_fc;
        r_read   <= req_read;
        r_byte   <= req_size == 2'd0;
        r_long   <= req_size == 2'd2;
        r_second <= 1'b0;
        r_dout   <= req_size == 2'd0 ? {2{req_wdata[7:0]}} : req_size == 2'd2 ? req_wdata[31:16] : req_wdata[15:0];
        r_wlo    <= req_wdata[15:0];
        r_rdata  <= '0;
        r_err    <= w_aerr ? 2'd2 : 2'd0;
      end
      if (r_state == WAIT && w_next == NEG) r_err <= !berr_q ? 2'd1 : 2'd3;
      if (r_state == LATCH)
        r_rdata <= r_byte ? {24'h0, r_addr[0] ? D_in[7:0] : D_in[15:8]} :
                   r_second ? {r_rdata[31:16], D_in} :
                   r_long ? {D_in, 16'h0} : {16'h0, D_in};
      if (r_state == NEG && w_next == ADR) begin
        r_addr   <= r_addr + ADDR_W'(2);
        r_second <= 1'b1;
        r_dout   <= r_wlo;
      end
    end
  // Reads enable data strobes with AS_n; writes wait one clock for data setup.
  always_comb begin
    w_as  = r_state inside {ASRT, DS, WAIT, LATCH};
    w_ds  = r_read ? w_as : r_state inside {DS, WAIT, LATCH};
    A_oe  = r_state inside {ADR, ASRT, DS, WAIT, LATCH, NEG};
    AS_n  = !w_as;
    RW_n  = !(A_oe && !r_read);
    UDS_n = !(w_ds && (!r_byte || !r_addr[0]));
    LDS_n = !(w_ds && (!r_byte || r_addr[0]));
    D_oe  = !r_read && r_state inside {ASRT, DS, WAIT, LATCH, NEG};
    A     = r_addr[ADDR_W-1:1];
    FC    = r_fc;
    D_out = r_dout;
    req_ready  = r_state == IDLE;
    resp_valid = r_state == RESP;
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end
endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: directed checks of m68k_bus_master transfers, errors and reset.
module tb_m68k_bus_master;
  logic C100 = 1'b0, RESET_n = 1'b0;
  logic req_valid = 1'b0, req_read = 1'b1;
  logic [23:0] req_addr = '0;
  logic [2:0] req_fc = '0;
  logic [1:0] req_size = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, A_oe, AS_n, RW_n, UDS_n, LDS_n, D_oe;
  logic [31:0] resp_rdata;
  logic [1:0] resp_err;
  logic [22:0] A;
  logic [2:0] FC;
  logic [15:0] D_out, D_in, din_val = '0;
  logic din_map = 1'b0, DTACK_n = 1'b0, BERR_n = 1'b1;
  int tests = 0, fails = 0;
  int lat, as_cnt;
  logic prev_as, uds_seen, lds_seen, seen;
  logic [22:0] a_cap [2];
  logic [15:0] d_cap [2];
  logic doe_cap [2], rw_cap [2];
  logic [2:0] fc_cap;
  logic [31:0] rd;
  logic [1:0] er;

  assign D_in = din_map ? (A == 23'h000800 ? 16'h1111 : 16'h2222) : din_val;

  m68k_bus_master #(.ADDR_W(24), .TIMEOUT_CYC(8)) dut (
    .C100(C100), .RESET_n(RESET_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_fc(req_fc), .req_size(req_size), .req_read(req_read),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .A(A), .FC(FC), .A_oe(A_oe), .AS_n(AS_n), .RW_n(RW_n),
    .UDS_n(UDS_n), .LDS_n(LDS_n), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .DTACK_n(DTACK_n), .BERR_n(BERR_n));

  always #5 C100 = ~C100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch the bus until resp_valid or maxc clocks pass.
  task automatic xfer(input logic [23:0] addr, input logic [1:0] size, input logic read,
                      input logic [31:0] wdata, input int maxc);
    @(negedge C100);
    req_addr = addr; req_size = size; req_read = read; req_wdata = wdata; req_fc = 3'd5;
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    @(posedge C100);
    #1 req_valid = 1'b0;
    lat = 0; as_cnt = 0; prev_as = 1'b1; uds_seen = 1'b0; lds_seen = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge C100);
      if (!AS_n && prev_as) begin
        if (as_cnt < 2) begin
          a_cap[as_cnt] = A; d_cap[as_cnt] = D_out; doe_cap[as_cnt] = D_oe;
          rw_cap[as_cnt] = RW_n; fc_cap = FC;
        end
        as_cnt++;
      end
      prev_as = AS_n;
      uds_seen |= !UDS_n;
      lds_seen |= !LDS_n;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_strobes", {AS_n, RW_n, UDS_n, LDS_n, A_oe, D_oe, resp_valid}, 7'b1111000);
    chk("rst_bus", {A, FC, D_out}, 0);
    chk("rst_resp", {resp_err, resp_rdata}, 0);
    @(negedge C100) RESET_n = 1'b1;

    din_val = 16'hBEEF;
    xfer(24'h001000, 2'd1, 1'b1, 32'h0, 40);
    chk("wr_lat", lat, 7);
    chk("wr_rdata", rd, 32'h0000BEEF);
    chk("wr_err", er, 0);
    chk("wr_lanes", {uds_seen, lds_seen}, 2'b11);
    chk("wr_as", as_cnt, 1);
    chk("wr_addr", a_cap[0], 23'h000800);
    chk("wr_fc_rw", {fc_cap, rw_cap[0]}, 4'b1011);

    xfer(24'hFFFFFE, 2'd2, 1'b0, 32'h12345678, 40);
    chk("lw_lat", lat, 13);
    chk("lw_as", as_cnt, 2);
    chk("lw_a0", a_cap[0], 23'h7FFFFF);
    chk("lw_d0", d_cap[0], 16'h1234);
    chk("lw_a1", a_cap[1], 23'h000000);
    chk("lw_d1", d_cap[1], 16'h5678);
    chk("lw_oe_rw", {doe_cap[0], doe_cap[1], rw_cap[0], rw_cap[1]}, 4'b1100);
    chk("lw_err", er, 0);

    din_val = 16'h00A5;
    xfer(24'h000003, 2'd0, 1'b1, 32'h0, 40);
    chk("br_lanes", {uds_seen, lds_seen}, 2'b01);
    chk("br_rdata", rd, 32'h000000A5);
    chk("br_lat", lat, 7);

    din_val = 16'h5A00;
    xfer(24'h000002, 2'd0, 1'b1, 32'h0, 40);
    chk("bre_lanes", {uds_seen, lds_seen}, 2'b10);
    chk("bre_rdata", rd, 32'h0000005A);

    xfer(24'h000001, 2'd0, 1'b0, 32'h000000AB, 40);
    chk("bw_lanes", {uds_seen, lds_seen}, 2'b01);
    chk("bw_data", {doe_cap[0], d_cap[0][7:0]}, 9'h1AB);

    din_map = 1'b1;
    xfer(24'h001000, 2'd2, 1'b1, 32'h0, 40);
    chk("lr_rdata", rd, 32'h11112222);
    chk("lr_lat", lat, 13);
    din_map = 1'b0;

    xfer(24'h000101, 2'd1, 1'b1, 32'h0, 40);
    chk("ae_lat", lat, 1);
    chk("ae_err", er, 2);
    chk("ae_as", as_cnt, 0);
    repeat (3) @(negedge C100);
    chk("ae_hold", {resp_valid, resp_err}, 3'b010);

    BERR_n = 1'b0;
    DTACK_n = 1'b0;
    xfer(24'h004000, 2'd2, 1'b1, 32'h0, 40);
    chk("be_err", er, 1);
    chk("be_as", as_cnt, 1);
    chk("be_lat", lat, 6);
    BERR_n = 1'b1;

    DTACK_n = 1'b1;
`ifdef M68K_BUS_TIMEOUT_EN
    xfer(24'h003000, 2'd1, 1'b1, 32'h0, 40);
    chk("to_err", er, 3);
    chk("to_lat", lat, 13);
    DTACK_n = 1'b0;
`else
    din_val = 16'h7777;
    xfer(24'h003000, 2'd1, 1'b1, 32'h0, 30);
    chk("nt_wait", {lat, as_cnt, AS_n}, {32'd0, 32'd1, 1'b0});
    DTACK_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge C100);
      if (resp_valid) begin
        seen = 1'b1; rd = resp_rdata; er = resp_err;
      end
    end
    chk("nt_done", {seen, er, rd}, {1'b1, 2'd0, 32'h00007777});
`endif

    DTACK_n = 1'b1;
    @(negedge C100);
    req_addr = 24'h002000; req_size = 2'd1; req_read = 1'b0; req_wdata = 32'h0000AAAA;
    req_valid = 1'b1;
    @(posedge C100);
    #1 req_valid = 1'b0;
    repeat (6) @(negedge C100);
    chk("mid_wait", {AS_n, D_oe}, 2'b01);
    RESET_n = 1'b0;
    #1;
    chk("mid_rst", {AS_n, RW_n, UDS_n, LDS_n, A_oe, D_oe, resp_valid}, 7'b1111000);
    @(negedge C100) RESET_n = 1'b1;
    DTACK_n = 1'b0;
    @(posedge C100);
    #1 chk("mid_ready", req_ready, 1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge C100);
      seen |= resp_valid;
    end
    chk("mid_noresp", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
